// File: rtl/traffic_light_pkg.sv
`default_nettype none
// ============================================================================
// Module      : traffic_light_pkg
// Description : State encoding, lamp bundle and default timing for the
//               traffic_light_param controller.
// Revision    : 1.0 - initial release
// ============================================================================
package traffic_light_pkg;

    typedef enum logic [2:0] {
        MG    = 3'd0,
        MY    = 3'd1,
        AR1   = 3'd2,
        SG    = 3'd3,
        SY    = 3'd4,
        AR2   = 3'd5,
        FLASH = 3'd6
    } tl_state_t;

    typedef struct packed {
        logic hg;
        logic hy;
        logic hr;
        logic fg;
        logic fy;
        logic fr;
    } lamps_t;

    localparam int unsigned c_def_tick_div = 50_000_000;
    localparam int unsigned c_def_cnt_w    = 8;
    localparam int unsigned c_def_t_mg     = 60;
    localparam int unsigned c_def_t_sg     = 30;
    localparam int unsigned c_def_t_y      = 5;
    localparam int unsigned c_def_t_ar     = 1;

    // One lamp per road; the unused code 7 falls back to red on both roads.
    function automatic lamps_t lamp_decode(input tl_state_t st, input logic blink);
        lamps_t l;
        l = '0;
        case (st)
            MG:       begin l.hg = 1'b1; l.fr = 1'b1; end
            MY:       begin l.hy = 1'b1; l.fr = 1'b1; end
            AR1, AR2: begin l.hr = 1'b1; l.fr = 1'b1; end
            SG:       begin l.hr = 1'b1; l.fg = 1'b1; end
            SY:       begin l.hr = 1'b1; l.fy = 1'b1; end
            FLASH:    begin l.hy = blink; l.fy = blink; end
            default:  begin l.hr = 1'b1; l.fr = 1'b1; end
        endcase
        return l;
    endfunction

endpackage
`default_nettype wire

// File: rtl/traffic_light_param_prescaler.sv
`default_nettype none
// ============================================================================
// Module      : tick_prescaler
// Description : Free-running 0..TICK_DIV-1 counter with a one-cycle tick
//               flagged while the count sits at its terminal value.
// Revision    : 1.0 - initial release
// ============================================================================
module tick_prescaler #(
    parameter int unsigned TICK_DIV = 50_000_000,
    parameter int unsigned CW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1
) (
    input  logic          clk,
    input  logic          rst,
    output logic          tick,
    output logic [CW-1:0] count
);

    logic [CW-1:0] r_count;
    logic          w_tick;

    assign w_tick = (r_count == CW'(TICK_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (w_tick) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

    assign tick  = w_tick;
    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/traffic_light_param.sv
`default_nettype none
// ============================================================================
// Module      : traffic_light_param
// Description : Main/side road traffic light controller with tick-based
//               timing and night flashing mode. Pedestrian request support
//               is built when TL_PED_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module traffic_light_param
    import traffic_light_pkg::*;
#(
    parameter int unsigned TICK_DIV = c_def_tick_div,
    parameter int unsigned CNT_W    = c_def_cnt_w,
    parameter int unsigned T_MG     = c_def_t_mg,
    parameter int unsigned T_SG     = c_def_t_sg,
    parameter int unsigned T_Y      = c_def_t_y,
    parameter int unsigned T_AR     = c_def_t_ar
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s,
    input  logic             ped_req,
    input  logic             night_mode,
    output logic             hg,
    output logic             hy,
    output logic             hr,
    output logic             fg,
    output logic             fy,
    output logic             fr,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] remain
);

    localparam int unsigned      c_div_w   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] c_mg_last = CNT_W'(T_MG - 1);
    localparam logic [CNT_W-1:0] c_sg_last = CNT_W'(T_SG - 1);
    localparam logic [CNT_W-1:0] c_y_last  = CNT_W'(T_Y - 1);
    localparam logic [CNT_W-1:0] c_ar_last = CNT_W'(T_AR - 1);
    localparam logic [CNT_W-1:0] c_el_max  = '1;

    logic               w_tick;
    logic [c_div_w-1:0] w_div_count_unused;

    tl_state_t          r_state,   w_state_nxt;
    logic [CNT_W-1:0]   r_elapsed, w_elapsed_nxt;
    logic               r_blink,   w_blink_nxt;
    logic               r_ped_pend, w_pend_nxt;
    lamps_t             r_lamps;
    logic [CNT_W-1:0]   r_remain,  w_remain_nxt;

    tick_prescaler #(
        .TICK_DIV (TICK_DIV),
        .CW       (c_div_w)
    ) u_prescaler (
        .clk   (clk),
        .rst   (rst),
        .tick  (w_tick),
        .count (w_div_count_unused)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= MG;
            r_elapsed  <= '0;
            r_blink    <= 1'b0;
            r_ped_pend <= 1'b0;
            r_lamps    <= lamp_decode(MG, 1'b0);
            r_remain   <= c_mg_last;
        end else begin
            r_state    <= w_state_nxt;
            r_elapsed  <= w_elapsed_nxt;
            r_blink    <= w_blink_nxt;
            r_ped_pend <= w_pend_nxt;
            r_lamps    <= lamp_decode(w_state_nxt, w_blink_nxt);
            r_remain   <= w_remain_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_elapsed_nxt = r_elapsed;
        w_blink_nxt   = r_blink;
        if (w_tick) begin
            w_blink_nxt = ~r_blink;
            case (r_state)
                MG: begin
                    if (night_mode) begin
                        w_state_nxt = FLASH;
                    end else if ((r_elapsed >= c_mg_last) && (s || r_ped_pend)) begin
                        w_state_nxt = MY;
                    end
                end
                MY:    if (r_elapsed == c_y_last)  w_state_nxt = AR1;
                AR1:   if (r_elapsed == c_ar_last) w_state_nxt = SG;
                SG:    if ((r_elapsed == c_sg_last) || !s) w_state_nxt = SY;
                SY:    if (r_elapsed == c_y_last)  w_state_nxt = AR2;
                AR2:   if (r_elapsed == c_ar_last) w_state_nxt = MG;
                FLASH: if (!night_mode)            w_state_nxt = AR2;
                default: w_state_nxt = MG;
            endcase
            // Saturate rather than wrap so a long MG stays past its minimum.
            if (w_state_nxt != r_state) begin
                w_elapsed_nxt = '0;
            end else if (r_elapsed != c_el_max) begin
                w_elapsed_nxt = r_elapsed + 1'b1;
            end
        end
    end

`ifdef TL_PED_EN
    always_comb begin
        w_pend_nxt = r_ped_pend;
        if ((w_state_nxt == SG) && (r_state != SG)) begin
            w_pend_nxt = 1'b0;
        end else if (ped_req) begin
            w_pend_nxt = 1'b1;
        end
    end
`else
    logic w_ped_req_unused;
    assign w_ped_req_unused = ped_req;
    assign w_pend_nxt       = 1'b0;
`endif

    always_comb begin
        w_remain_nxt = '0;
        case (w_state_nxt)
            MG:       w_remain_nxt = (w_elapsed_nxt < c_mg_last) ? (c_mg_last - w_elapsed_nxt) : '0;
            MY, SY:   w_remain_nxt = c_y_last - w_elapsed_nxt;
            AR1, AR2: w_remain_nxt = c_ar_last - w_elapsed_nxt;
            SG:       w_remain_nxt = c_sg_last - w_elapsed_nxt;
            default:  w_remain_nxt = '0;
        endcase
    end

    assign hg     = r_lamps.hg;
    assign hy     = r_lamps.hy;
    assign hr     = r_lamps.hr;
    assign fg     = r_lamps.fg;
    assign fy     = r_lamps.fy;
    assign fr     = r_lamps.fr;
    assign state  = r_state;
    assign remain = r_remain;

endmodule
`default_nettype wire

// File: tb/tb_traffic_light_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_traffic_light_param
// Description : Self-checking bench: per-cycle reference model plus directed
//               scenarios with hand-computed expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_traffic_light_param;

    localparam int TD     = 4;
    localparam int CW     = 4;
    localparam int TMG    = 6;
    localparam int TSG    = 4;
    localparam int TY     = 2;
    localparam int TAR    = 1;
    localparam int EL_MAX = (1 << CW) - 1;

    logic          clk;
    logic          rst;
    logic          s;
    logic          ped_req;
    logic          night_mode;
    logic          hg, hy, hr, fg, fy, fr;
    logic [2:0]    state;
    logic [CW-1:0] remain;

    int n_cmp = 0;
    int n_bad = 0;

    traffic_light_param #(
        .TICK_DIV (TD),
        .CNT_W    (CW),
        .T_MG     (TMG),
        .T_SG     (TSG),
        .T_Y      (TY),
        .T_AR     (TAR)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .s          (s),
        .ped_req    (ped_req),
        .night_mode (night_mode),
        .hg         (hg),
        .hy         (hy),
        .hr         (hr),
        .fg         (fg),
        .fy         (fy),
        .fr         (fr),
        .state      (state),
        .remain     (remain)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Phase codes follow the required output encoding: 0 MG .. 6 FLASH.
    function automatic int dur_of(input int ph);
        case (ph)
            0:       return TMG;
            1, 4:    return TY;
            2, 5:    return TAR;
            3:       return TSG;
            default: return 0;
        endcase
    endfunction

    // {hg,hy,hr,fg,fy,fr}
    function automatic int lamps_of(input int ph, input bit blink);
        case (ph)
            0:       return 6'b100001;
            1:       return 6'b010001;
            2, 5:    return 6'b001001;
            3:       return 6'b001100;
            4:       return 6'b001010;
            6:       return blink ? 6'b010010 : 6'b000000;
            default: return 6'b001001;
        endcase
    endfunction

    int m_ph, m_el, m_div;
    bit m_pend, m_blink, m_valid;

    initial begin
        m_valid = 1'b0;
        m_ph = 0; m_el = 0; m_div = 0; m_pend = 1'b0; m_blink = 1'b0;
    end

    always @(posedge clk) begin
        int  nxt;
        bit  last;
        if (rst) begin
            m_valid = 1'b1;
            m_ph = 0; m_el = 0; m_div = 0; m_pend = 1'b0; m_blink = 1'b0;
        end else if (m_valid) begin
            nxt = m_ph;
            if (m_div == TD - 1) begin
                last = (m_el + 1 >= dur_of(m_ph));
                case (m_ph)
                    0: begin
                        if (night_mode) nxt = 6;
                        else if (last && (s || m_pend)) nxt = 1;
                    end
                    3:       if (last || !s) nxt = 4;
                    6:       if (!night_mode) nxt = 5;
                    default: if (last) nxt = (m_ph + 1) % 6;
                endcase
                m_blink = !m_blink;
                m_el = (nxt != m_ph) ? 0 : ((m_el < EL_MAX) ? m_el + 1 : EL_MAX);
            end
`ifdef TL_PED_EN
            if (nxt == 3 && m_ph != 3) m_pend = 1'b0;
            else if (ped_req)          m_pend = 1'b1;
`endif
            m_ph  = nxt;
            m_div = (m_div + 1) % TD;
        end
    end

    always @(negedge clk) begin
        int exp_rem;
        if (m_valid) begin
            exp_rem = dur_of(m_ph) - 1 - m_el;
            if (exp_rem < 0) exp_rem = 0;
            chk("model_state",  int'(state), m_ph);
            chk("model_lamps",  int'({hg, hy, hr, fg, fy, fr}), lamps_of(m_ph, m_blink));
            chk("model_remain", int'(remain), exp_rem);
            chk("no_dual_green", int'(hg & fg), 0);
        end
    end

    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        edges(1);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; s = 1'b0; ped_req = 1'b0; night_mode = 1'b0;
        edges(2);
        rst = 1'b0;
        chk("rst_state",  int'(state), 0);
        chk("rst_lamps",  int'({hg, hy, hr, fg, fy, fr}), 6'b100001);
        chk("rst_remain", int'(remain), 5);

        // S1: no demand, MG holds well beyond the elapsed counter range
        edges(200);
        chk("s1_state",  int'(state), 0);
        chk("s1_remain", int'(remain), 0);
        chk("s1_hg",     int'(hg), 1);

        // S4: single pedestrian pulse, no vehicle
        do_reset();
        edges(5);
        ped_req = 1'b1;
        edges(1);
        ped_req = 1'b0;
        edges(18);
`ifdef TL_PED_EN
        chk("s4_state_e24", int'(state), 1);
`else
        chk("s4_state_e24", int'(state), 0);
`endif
        edges(56);
        chk("s4_state_e80", int'(state), 0);

        // S2: vehicle held from reset, one full cycle of 64 clocks
        s = 1'b1;
        do_reset();
        edges(23); chk("s2_mg_e23",  int'(state), 0);
        edges(1);  chk("s2_my_e24",  int'(state), 1);
                   chk("s2_my_rem",  int'(remain), 1);
        edges(8);  chk("s2_ar1_e32", int'(state), 2);
        edges(4);  chk("s2_sg_e36",  int'(state), 3);
                   chk("s2_sg_rem",  int'(remain), 3);
                   chk("s2_sg_lamp", int'({hg, hy, hr, fg, fy, fr}), 6'b001100);
        edges(16); chk("s2_sy_e52",  int'(state), 4);
        edges(8);  chk("s2_ar2_e60", int'(state), 5);
        edges(4);  chk("s2_mg_e64",  int'(state), 0);
                   chk("s2_mg_rem",  int'(remain), 5);

        // S3: vehicle leaves while SG has elapsed=1
        do_reset();
        edges(43);
        chk("s3_sg_e43", int'(state), 3);
        s = 1'b0;
        edges(1);
        chk("s3_sy_e44",  int'(state), 4);
        chk("s3_sy_rem",  int'(remain), 1);

        // S6: reset pulse in SY
        edges(3);
        rst = 1'b1;
        edges(1);
        rst = 1'b0;
        chk("s6_state",  int'(state), 0);
        chk("s6_lamps",  int'({hg, hy, hr, fg, fy, fr}), 6'b100001);
        chk("s6_remain", int'(remain), 5);

        // S5: night mode entry, blink, exit through AR2
        night_mode = 1'b1;
        edges(4);
        chk("s5_flash",   int'(state), 6);
        chk("s5_blink_1", int'({hg, hy, hr, fg, fy, fr}), 6'b010010);
        edges(4);
        chk("s5_blink_0", int'({hg, hy, hr, fg, fy, fr}), 6'b000000);
        chk("s5_rem",     int'(remain), 0);
        night_mode = 1'b0;
        edges(4);
        chk("s5_ar2", int'(state), 5);
        edges(4);
        chk("s5_mg",  int'(state), 0);
        edges(8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
